tx_arbiter: RTL
===============

// Module: tx_arbiter
// PURPOSE
//  Shares one UART transmitter (tx_en_sig/tx_data/tx_done_sig handshake) between N byte sources.
//  Round-robin grant, one byte per grant. Grant data latched, tx_en_sig held until done.
//  Per-requester ack/error pulses; watchdog aborts a stuck transfer.
//  Sits between the test/command generators and the tx module in the serial_port top.
// PARAMETERS
//  N           4        number of requesters (>=1)
//  GAP_CYCLES  2        idle cycles after each transfer before next arbitration (>=1)
//  TIMEOUT     100_000  max cycles in SEND waiting for tx_done_sig; 0 disables watchdog
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous reset, active low
//  req          in   N      per-requester level request; req[i] high = byte pending
//  req_data     in   N*8    flat data bus, requester i on [8*i+7:8*i]
//  ack          out  N      one-cycle pulse: requester i's byte completed (tx_done_sig seen)
//  err          out  N      one-cycle pulse: requester i's byte aborted by watchdog
//  busy         out  1      high in SEND and GAP
//  grant_idx    out  IW     index of current/last grant; IW = (N>1) ? $clog2(N) : 1
//  tx_en_sig    out  1      to tx module: transmit enable, level, held for whole byte
//  tx_data      out  8      to tx module: byte, stable while tx_en_sig high
//  tx_done_sig  in   1      from tx module: one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, tx_en_sig=0, tx_data=8'h00, ack=0, err=0, busy=0, grant_idx=0,
//   rr pointer=0, gap/watchdog counters=0. Async assert, sync release; outputs all registered.
//  FSM: IDLE -> SEND -> GAP -> IDLE.
//  IDLE: if |req, pick first i with req[i]=1 scanning ptr, ptr+1, ... mod N.
//   Next edge: latch req_data[i] into tx_data, grant_idx=i, tx_en_sig=1, state=SEND, wd=0.
//   Latency: req high in cycle k (IDLE) -> tx_en_sig high in cycle k+1.
//  SEND: tx_en_sig=1, tx_data frozen (later req_data changes ignored); wd increments each cycle.
//   tx_done_sig=1 in cycle d -> in d+1: tx_en_sig=0, ack[grant_idx]=1 for one cycle,
//   ptr=(grant_idx+1) mod N, state=GAP.
//   TIMEOUT!=0 and wd==TIMEOUT-1 with no done -> next edge: tx_en_sig=0, err[grant_idx]=1
//   for one cycle, ptr advances as for ack, state=GAP.
//   Same cycle done and wd==TIMEOUT-1: done wins (ack, no err).
//  GAP: tx_en_sig=0; stays exactly GAP_CYCLES cycles, then IDLE; req ignored here.
//  tx_done_sig outside SEND is ignored (no ack, no state change).
//  Requester rule: after ack/err in cycle d+1, requester must drop req by cycle d+2 or
//   present next byte. A req still high at IDLE is a new request.
//  req[i] dropped while i is granted: transfer still completes; ack still pulses.
//  Fairness: with all req high, grants go 0,1,2,...,N-1,0 with no starvation.
//  N=1: ptr stays 0; grant_idx stays 0.
//  Reset mid-SEND: tx_en_sig drops immediately (async); no ack/err issued; arbitration restarts at 0.
//  ack/err never both high; at most one bit of ack|err high in any cycle.
// TESTING  (bench: N=4, GAP_CYCLES=2, TIMEOUT=20, tx model returns done 5 cycles after en)
//  1. req=4'b0100, data2=8'h31 -> tx_en_sig=1 next cycle with tx_data=8'h31; ack=4'b0100
//     one cycle after done; busy low 2 cycles later.
//  2. req=4'b1111 held, data i=8'h40+i -> bytes 40,41,42,43,40 in order; 2 idle cycles between.
//  3. req=4'b1010 after grant 1 -> next grant 3, then 1; never 0 or 2.
//  4. tx model never returns done -> tx_en_sig high 20 cycles, then err=4'b0001 one cycle,
//     no ack; next requester served.
//  5. done coincident with wd==19 -> ack pulse, no err; spurious done in IDLE -> no ack.
//  6. rst_n low mid-SEND -> tx_en_sig/ack/err 0 at once; after release req=4'b1000 -> grant_idx=3.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one byte transmitter among N requesters.
// One byte per grant, a fixed idle gap afterwards, and a watchdog that aborts a stuck byte.
module tx_arbiter #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 100_000,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*8-1:0]  req_data,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    err,
  output logic            busy,
  output logic [IW-1:0]   grant_idx,
  output logic            tx_en_sig,
  output logic [7:0]      tx_data,
  input  logic            tx_done_sig
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST  = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW:0]   N_WIDE   = (IW + 1)'(N);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   pick;
  logic [IW:0]     sum;
  logic            found;
  logic            wd_expire;
  logic [WW-1:0]   wd;
  logic [GW-1:0]   gap_cnt;

  // Scan requesters starting at ptr, wrapping once; first hit wins.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    sum       = '0;
    state_nxt = state;
    ptr_nxt   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    wd_expire = (TIMEOUT != 0) && (wd == WD_LAST);
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (IW + 1)'(off);
      if (sum >= N_WIDE) sum = sum - N_WIDE;
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
    case (state)
      IDLE:    if (found) state_nxt = SEND;
      SEND:    if (tx_done_sig || wd_expire) state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      tx_en_sig <= 1'b0;
      tx_data   <= 8'h00;
      ack       <= '0;
      err       <= '0;
      busy      <= 1'b0;
      wd        <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      err   <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data   <= req_data[8*pick +: 8];
            grant_idx <= pick;
            tx_en_sig <= 1'b1;
            busy      <= 1'b1;
            wd        <= '0;
          end
        end
        SEND: begin
          // A completion in the watchdog's last cycle still counts as success.
          if (tx_done_sig) begin
            tx_en_sig <= 1'b0;
            ack       <= N'(1) << grant_idx;
            ptr       <= ptr_nxt;
            gap_cnt   <= '0;
          end else if (wd_expire) begin
            tx_en_sig <= 1'b0;
            err       <= N'(1) << grant_idx;
            ptr       <= ptr_nxt;
            gap_cnt   <= '0;
          end else if (TIMEOUT != 0) begin
            wd <= wd + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) busy <= 1'b0;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          tx_en_sig <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
